// File: rtl/single_regfile.sv
// Register file with two combinational read ports, one debug read port and one clocked write port.
// Register 0 always reads zero. Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module single_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_ra1,
  input  logic [ADDR_W-1:0] i_ra2,
  input  logic [ADDR_W-1:0] i_rad,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wa,
  input  logic [DATA_W-1:0] i_wd,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2,
  output logic [DATA_W-1:0] o_dbg
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic              wr_en;

  // A write lands only when it is not overridden by reset and does not target r0.
  assign wr_en = i_we && !i_rst && (i_wa != '0);

  // NOTE: every entry is cleared on reset, so this array becomes flops rather than
  // a RAM macro; that is what guarantees defined reads after the first reset edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: non-blocking so every read in this edge sees pre-edge contents.
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[i_wa] <= i_wd;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign o_rd1 = (i_ra1 == '0) ? '0 : (wr_en && (i_ra1 == i_wa)) ? i_wd : regs_q[i_ra1];
  assign o_rd2 = (i_ra2 == '0) ? '0 : (wr_en && (i_ra2 == i_wa)) ? i_wd : regs_q[i_ra2];
  assign o_dbg = (i_rad == '0) ? '0 : (wr_en && (i_rad == i_wa)) ? i_wd : regs_q[i_rad];
`else
  // Without forwarding a same-cycle read returns the pre-edge value.
  assign o_rd1 = (i_ra1 == '0) ? '0 : regs_q[i_ra1];
  assign o_rd2 = (i_ra2 == '0) ? '0 : regs_q[i_ra2];
  assign o_dbg = (i_rad == '0) ? '0 : regs_q[i_rad];
`endif

endmodule
